// File: rtl/native_port_buffer.sv
// native_port_buffer: first-word-fall-through buffering of command, write-data and read-data
// streams between the Wishbone-to-native bridge and the controller crossbar.
// Define NATIVE_BUF_RDATA_FIFO_EN for a credited read-data FIFO; otherwise read data passes straight through.
module native_port_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,

    input  logic                s_cmd_valid,
    output logic                s_cmd_ready,
    input  logic                s_cmd_last,
    input  logic                s_cmd_payload_we,
    input  logic [ADDR_W-1:0]   s_cmd_payload_addr,

    input  logic                s_wdata_valid,
    output logic                s_wdata_ready,
    input  logic [DATA_W-1:0]   s_wdata_payload_data,
    input  logic [DATA_W/8-1:0] s_wdata_payload_we,

    output logic                s_rdata_valid,
    input  logic                s_rdata_ready,
    output logic [DATA_W-1:0]   s_rdata_payload_data,

    output logic                m_cmd_valid,
    input  logic                m_cmd_ready,
    output logic                m_cmd_last,
    output logic                m_cmd_payload_we,
    output logic [ADDR_W-1:0]   m_cmd_payload_addr,

    output logic                m_wdata_valid,
    input  logic                m_wdata_ready,
    output logic [DATA_W-1:0]   m_wdata_payload_data,
    output logic [DATA_W/8-1:0] m_wdata_payload_we,

    input  logic                m_rdata_valid,
    output logic                m_rdata_ready,
    input  logic [DATA_W-1:0]   m_rdata_payload_data,

    output logic                idle
);
    localparam int AW    = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;
    localparam int CMD_W = ADDR_W + 2;
    localparam int WD_W  = DATA_W + BE_W;

    // Assertion reaches the state asynchronously; release is retimed so state leaves reset on the first edge.
    logic rst_sync_n;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rst_sync_n <= 1'b0;
        else            rst_sync_n <= 1'b1;
    end

    logic [CMD_W-1:0] cmd_mem [DEPTH];
    logic [AW:0]      cmd_wp, cmd_rp;
    logic             cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [CMD_W-1:0] cmd_head;

    assign cmd_full    = (cmd_wp[AW-1:0] == cmd_rp[AW-1:0]) && (cmd_wp[AW] != cmd_rp[AW]);
    assign cmd_empty   = (cmd_wp == cmd_rp);
    assign s_cmd_ready = !cmd_full;
    assign cmd_push    = s_cmd_valid & s_cmd_ready;
    assign cmd_pop     = m_cmd_valid & m_cmd_ready;
    assign cmd_head    = cmd_mem[cmd_rp[AW-1:0]];
    assign {m_cmd_last, m_cmd_payload_we, m_cmd_payload_addr} = cmd_head;

    always_ff @(posedge sys_clk) begin
        if (cmd_push) cmd_mem[cmd_wp[AW-1:0]] <= {s_cmd_last, s_cmd_payload_we, s_cmd_payload_addr};
    end

    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cmd_wp <= '0;
            cmd_rp <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + (AW+1)'(1);
            if (cmd_pop)  cmd_rp <= cmd_rp + (AW+1)'(1);
        end
    end

    logic [WD_W-1:0] wd_mem [DEPTH];
    logic [AW:0]     wd_wp, wd_rp;
    logic            wd_full, wd_empty, wd_push, wd_pop;

    assign wd_full       = (wd_wp[AW-1:0] == wd_rp[AW-1:0]) && (wd_wp[AW] != wd_rp[AW]);
    assign wd_empty      = (wd_wp == wd_rp);
    assign s_wdata_ready = !wd_full;
    assign m_wdata_valid = !wd_empty;
    assign wd_push       = s_wdata_valid & s_wdata_ready;
    assign wd_pop        = m_wdata_valid & m_wdata_ready;
    assign {m_wdata_payload_data, m_wdata_payload_we} = wd_mem[wd_rp[AW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (wd_push) wd_mem[wd_wp[AW-1:0]] <= {s_wdata_payload_data, s_wdata_payload_we};
    end

    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            wd_wp <= '0;
            wd_rp <= '0;
        end else begin
            if (wd_push) wd_wp <= wd_wp + (AW+1)'(1);
            if (wd_pop)  wd_rp <= wd_rp + (AW+1)'(1);
        end
    end

    logic        rd_empty;
    logic [AW:0] rd_out;

`ifdef NATIVE_BUF_RDATA_FIFO_EN
    logic [DATA_W-1:0] rd_mem [DEPTH];
    logic [AW:0]       rd_wp, rd_rp, rd_count;
    logic              rd_full, rd_push, rd_pop, rd_issue;
    logic [AW+1:0]     credit_used;

    assign rd_count             = rd_wp - rd_rp;
    assign rd_full              = (rd_wp[AW-1:0] == rd_rp[AW-1:0]) && (rd_wp[AW] != rd_rp[AW]);
    assign rd_empty             = (rd_wp == rd_rp);
    assign m_rdata_ready        = !rd_full;
    assign s_rdata_valid        = !rd_empty;
    assign s_rdata_payload_data = rd_mem[rd_rp[AW-1:0]];
    assign rd_push              = m_rdata_valid & m_rdata_ready;
    assign rd_pop               = s_rdata_valid & s_rdata_ready;
    assign rd_issue             = cmd_pop & ~m_cmd_payload_we;

    // Reads are held back until the FIFO is guaranteed room for every beat already owed.
    assign credit_used = {1'b0, rd_out} + {1'b0, rd_count};
    assign m_cmd_valid = !cmd_empty & (m_cmd_payload_we | (credit_used < (AW+2)'(DEPTH)));

    always_ff @(posedge sys_clk) begin
        if (rd_push) rd_mem[rd_wp[AW-1:0]] <= m_rdata_payload_data;
    end

    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rd_wp  <= '0;
            rd_rp  <= '0;
            rd_out <= '0;
        end else begin
            if (rd_push) rd_wp <= rd_wp + (AW+1)'(1);
            if (rd_pop)  rd_rp <= rd_rp + (AW+1)'(1);
            if (rd_issue && !rd_push)      rd_out <= rd_out + (AW+1)'(1);
            else if (!rd_issue && rd_push) rd_out <= rd_out - (AW+1)'(1);
        end
    end
`else
    assign rd_empty             = 1'b1;
    assign rd_out               = '0;
    assign s_rdata_valid        = m_rdata_valid & sys_rst_n;
    assign m_rdata_ready        = s_rdata_ready;
    assign s_rdata_payload_data = m_rdata_payload_data;
    assign m_cmd_valid          = !cmd_empty;
`endif

    assign idle = cmd_empty & wd_empty & rd_empty & (rd_out == '0);

endmodule

// File: tb/tb_native_port_buffer.sv
// Bench for native_port_buffer: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations (fill, latency, simultaneous push/pop, async reset, read path).
module tb_native_port_buffer;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int DEPTH  = 4;
    localparam int BE_W   = DATA_W / 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              s_cmd_valid, s_cmd_ready, s_cmd_last, s_cmd_payload_we;
    logic [ADDR_W-1:0] s_cmd_payload_addr;
    logic              s_wdata_valid, s_wdata_ready;
    logic [DATA_W-1:0] s_wdata_payload_data;
    logic [BE_W-1:0]   s_wdata_payload_we;
    logic              s_rdata_valid, s_rdata_ready;
    logic [DATA_W-1:0] s_rdata_payload_data;
    logic              m_cmd_valid, m_cmd_ready, m_cmd_last, m_cmd_payload_we;
    logic [ADDR_W-1:0] m_cmd_payload_addr;
    logic              m_wdata_valid, m_wdata_ready;
    logic [DATA_W-1:0] m_wdata_payload_data;
    logic [BE_W-1:0]   m_wdata_payload_we;
    logic              m_rdata_valid, m_rdata_ready;
    logic [DATA_W-1:0] m_rdata_payload_data;
    logic              idle;

    native_port_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_last(s_cmd_last),
        .s_cmd_payload_we(s_cmd_payload_we), .s_cmd_payload_addr(s_cmd_payload_addr),
        .s_wdata_valid(s_wdata_valid), .s_wdata_ready(s_wdata_ready),
        .s_wdata_payload_data(s_wdata_payload_data), .s_wdata_payload_we(s_wdata_payload_we),
        .s_rdata_valid(s_rdata_valid), .s_rdata_ready(s_rdata_ready),
        .s_rdata_payload_data(s_rdata_payload_data),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_last(m_cmd_last),
        .m_cmd_payload_we(m_cmd_payload_we), .m_cmd_payload_addr(m_cmd_payload_addr),
        .m_wdata_valid(m_wdata_valid), .m_wdata_ready(m_wdata_ready),
        .m_wdata_payload_data(m_wdata_payload_data), .m_wdata_payload_we(m_wdata_payload_we),
        .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready),
        .m_rdata_payload_data(m_rdata_payload_data),
        .idle(idle)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed { logic last; logic we; logic [ADDR_W-1:0] addr; } cmd_t;
    typedef struct packed { logic [DATA_W-1:0] data; logic [BE_W-1:0] be; } wd_t;

    cmd_t              cq[$];
    wd_t               wq[$];
    logic [DATA_W-1:0] rq[$];
    int                rd_out_m = 0;
    bit                m_sync = 0;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit e_m_cmd_valid();
        if (cq.size() == 0) return 1'b0;
        return cq[0].we || ((rd_out_m + rq.size()) < DEPTH);
    endfunction

    function automatic bit e_s_rdata_valid();
`ifdef NATIVE_BUF_RDATA_FIFO_EN
        return rq.size() > 0;
`else
        return m_rdata_valid && sys_rst_n;
`endif
    endfunction

    function automatic bit e_m_rdata_ready();
`ifdef NATIVE_BUF_RDATA_FIFO_EN
        return rq.size() < DEPTH;
`else
        return s_rdata_ready;
`endif
    endfunction

    // Reference model: plain queues advanced on each clock edge from the bench-side view of the handshakes.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cq.delete(); wq.delete(); rq.delete();
            rd_out_m = 0;
            m_sync   = 0;
        end else begin
            if (m_sync) begin
                bit c_push, c_pop, w_push, w_pop, issue, r_push, r_pop;
                c_push = s_cmd_valid && (cq.size() < DEPTH);
                c_pop  = e_m_cmd_valid() && m_cmd_ready;
                issue  = c_pop && !cq[0].we;
                w_push = s_wdata_valid && (wq.size() < DEPTH);
                w_pop  = (wq.size() > 0) && m_wdata_ready;
`ifdef NATIVE_BUF_RDATA_FIFO_EN
                r_push = m_rdata_valid && e_m_rdata_ready();
                r_pop  = e_s_rdata_valid() && s_rdata_ready;
`else
                r_push = 1'b0;
                r_pop  = 1'b0;
`endif
                if (c_pop) void'(cq.pop_front());
                if (w_pop) void'(wq.pop_front());
                if (r_pop) void'(rq.pop_front());
                if (c_push) cq.push_back({s_cmd_last, s_cmd_payload_we, s_cmd_payload_addr});
                if (w_push) wq.push_back({s_wdata_payload_data, s_wdata_payload_we});
                if (r_push) rq.push_back(m_rdata_payload_data);
                rd_out_m = rd_out_m + int'(issue) - int'(r_push);
            end
            m_sync = 1;
        end
    end

    always @(negedge sys_clk) begin
        bit ecv;
        ecv = e_m_cmd_valid();
        chk("s_cmd_ready", s_cmd_ready, cq.size() < DEPTH);
        chk("m_cmd_valid", m_cmd_valid, ecv);
        if (ecv) chk("m_cmd_payload", {m_cmd_last, m_cmd_payload_we, m_cmd_payload_addr}, cq[0]);
        chk("s_wdata_ready", s_wdata_ready, wq.size() < DEPTH);
        chk("m_wdata_valid", m_wdata_valid, wq.size() > 0);
        if (wq.size() > 0) begin
            chk("m_wdata_data", m_wdata_payload_data, wq[0].data);
            chk("m_wdata_be", m_wdata_payload_we, wq[0].be);
        end
        chk("s_rdata_valid", s_rdata_valid, e_s_rdata_valid());
        chk("m_rdata_ready", m_rdata_ready, e_m_rdata_ready());
`ifdef NATIVE_BUF_RDATA_FIFO_EN
        if (rq.size() > 0) chk("s_rdata_data", s_rdata_payload_data, rq[0]);
`else
        chk("s_rdata_data", s_rdata_payload_data, m_rdata_payload_data);
`endif
        chk("idle", idle, cq.size() == 0 && wq.size() == 0 && rq.size() == 0 && rd_out_m == 0);
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge sys_clk);
    endtask

    initial begin
        int pops;
        sys_rst_n = 1'b0;
        s_cmd_valid = 0; s_cmd_last = 0; s_cmd_payload_we = 0; s_cmd_payload_addr = '0;
        s_wdata_valid = 0; s_wdata_payload_data = '0; s_wdata_payload_we = '0;
        s_rdata_ready = 1; m_cmd_ready = 1; m_wdata_ready = 0;
        m_rdata_valid = 1; m_rdata_payload_data = '0;
        step(); step();

        chk("rst_s_cmd_ready", s_cmd_ready, 1);
        chk("rst_s_wdata_ready", s_wdata_ready, 1);
        chk("rst_m_cmd_valid", m_cmd_valid, 0);
        chk("rst_m_wdata_valid", m_wdata_valid, 0);
        chk("rst_s_rdata_valid", s_rdata_valid, 0);
        chk("rst_m_rdata_ready", m_rdata_ready, 1);
        chk("rst_idle", idle, 1);
        m_rdata_valid = 0;

        // Release with a push already pending: ignored on edge 1, accepted on edge 2.
        sys_rst_n = 1; s_cmd_valid = 1; s_cmd_payload_we = 1; s_cmd_last = 1; s_cmd_payload_addr = 32'h99;
        step();
        mid(); chk("sync_edge1_valid", m_cmd_valid, 0);
        step();
        s_cmd_valid = 0;
        mid();
        chk("lat_n1_valid", m_cmd_valid, 1);
        chk("lat_payload", m_cmd_payload_addr, 32'h99);
        chk("lat_n1_idle", idle, 0);
        step();
        mid();
        chk("lat_n2_valid", m_cmd_valid, 0);
        chk("lat_n2_idle", idle, 1);

        // Fill both FIFOs past capacity with nothing draining.
        step();
        m_cmd_ready = 0; m_wdata_ready = 0;
        for (int i = 0; i < 5; i++) begin
            s_cmd_valid = 1; s_cmd_payload_we = 1; s_cmd_last = (i == 4);
            s_cmd_payload_addr = 32'h10 + i;
            s_wdata_valid = 1; s_wdata_payload_data = {8{32'(i + 1)}}; s_wdata_payload_we = 32'(32'hF << i);
            mid(); chk("fill_cmd_ready", s_cmd_ready, i < 4);
            step();
        end
        s_cmd_valid = 0; s_wdata_valid = 0; m_cmd_ready = 1; m_wdata_ready = 1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("drain_valid", m_cmd_valid, 1);
            chk("drain_addr", m_cmd_payload_addr, 32'h10 + i);
            chk("drain_wdata", m_wdata_payload_data, {8{32'(i + 1)}});
            step();
        end
        mid();
        chk("drain_empty", m_cmd_valid, 0);
        chk("drain_wd_empty", m_wdata_valid, 0);

        // Occupancy 2, then push and pop together for 10 cycles.
        step();
        m_cmd_ready = 0; s_cmd_valid = 1; s_cmd_payload_we = 1; s_cmd_last = 0;
        s_cmd_payload_addr = 32'h20; step();
        s_cmd_payload_addr = 32'h21; step();
        m_cmd_ready = 1;
        for (int k = 0; k < 10; k++) begin
            s_cmd_payload_addr = 32'h22 + k;
            mid(); chk("simul_head", m_cmd_payload_addr, 32'h20 + k);
            step();
        end
        s_cmd_valid = 0;
        for (int k = 0; k < 2; k++) begin
            mid(); chk("simul_tail", m_cmd_payload_addr, 32'h2A + k);
            step();
        end
        mid(); chk("simul_empty", m_cmd_valid, 0);

        // Mid-cycle asynchronous reset with entries queued.
        step();
        m_cmd_ready = 0; m_wdata_ready = 0;
        for (int i = 0; i < 3; i++) begin
            s_cmd_valid = 1; s_cmd_payload_addr = 32'h30 + i;
            s_wdata_valid = (i < 2); s_wdata_payload_data = {8{32'hC0DE0000 + i}};
            step();
        end
        s_cmd_valid = 0; s_wdata_valid = 0;
        #2 sys_rst_n = 0;
        #1;
        chk("arst_m_cmd_valid", m_cmd_valid, 0);
        chk("arst_m_wdata_valid", m_wdata_valid, 0);
        chk("arst_idle", idle, 1);
        step(); step();
        sys_rst_n = 1; m_cmd_ready = 1; m_wdata_ready = 1;
        for (int i = 0; i < 4; i++) begin
            mid(); chk("arst_no_stale", m_cmd_valid, 0);
            step();
        end

`ifdef NATIVE_BUF_RDATA_FIFO_EN
        // Read credit: five reads with no returning data.
        m_rdata_valid = 0; s_rdata_ready = 0; m_cmd_ready = 1; pops = 0;
        for (int i = 0; i < 9; i++) begin
            s_cmd_valid = (i < 5); s_cmd_payload_we = 0; s_cmd_payload_addr = 32'h40 + i;
            mid(); if (m_cmd_valid && m_cmd_ready) pops++;
            step();
        end
        s_cmd_valid = 0;
        chk("credit_pops", pops, 4);
        mid();
        chk("credit_block", m_cmd_valid, 0);
        chk("credit_head", m_cmd_payload_addr, 32'h44);
        step();
        m_rdata_valid = 1; m_rdata_payload_data = {32{8'h3C}};
        mid(); chk("credit_rd_ready", m_rdata_ready, 1);
        step();
        m_rdata_valid = 0;
        mid();
        chk("credit_after_beat", m_cmd_valid, 0);
        chk("credit_s_rdata_valid", s_rdata_valid, 1);
        step();
        mid(); chk("credit_still_blocked", m_cmd_valid, 0);
        step();
        s_rdata_ready = 1;
        mid(); chk("credit_rdata", s_rdata_payload_data, {32{8'h3C}});
        step();
        s_rdata_ready = 0;
        mid(); chk("credit_release", m_cmd_valid, 1);
        step();
        m_rdata_valid = 1; s_rdata_ready = 1;
        for (int i = 0; i < 4; i++) begin
            m_rdata_payload_data = {8{32'hBEEF0000 + i}};
            step();
        end
        m_rdata_valid = 0;
        step(); step();
        mid(); chk("credit_idle", idle, 1);
        step();
`else
        // Combinational read pass-through with upstream stalled.
        m_rdata_valid = 1; m_rdata_payload_data = {32{8'hA5}}; s_rdata_ready = 0;
        #1;
        chk("pt_m_rdata_ready", m_rdata_ready, 0);
        chk("pt_s_rdata_valid", s_rdata_valid, 1);
        chk("pt_s_rdata_data", s_rdata_payload_data, {32{8'hA5}});
        mid(); step();
        m_rdata_valid = 0; s_rdata_ready = 1;
`endif
        mid(); chk("final_idle", idle, 1);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
